// File: rtl/lvds_rx_word_aligner.sv
// lvds_rx_word_aligner: per-lane bitslip training against a fixed word pattern,
// with per-lane/aggregate lock and error reporting and a registered data path.
module lvds_rx_word_aligner #(
    parameter int                CHANNELS      = 4,
    parameter int                FACTOR        = 6,
    parameter logic [FACTOR-1:0] TRAIN_PATTERN = 6'b111000,
    parameter int                MATCH_COUNT   = 16,
    parameter int                SLIP_WAIT     = 4,
    parameter int                MAX_SLIPS     = 2 * FACTOR
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         align_req,
    input  logic [CHANNELS*FACTOR-1:0]   rx_data,
    input  logic                         rx_valid,
    output logic [CHANNELS-1:0]          bitslip,
    output logic [CHANNELS-1:0]          ch_locked,
    output logic [CHANNELS-1:0]          ch_error,
    output logic                         all_locked,
    output logic                         busy,
    output logic [CHANNELS*FACTOR-1:0]   data_out,
    output logic                         data_valid
);
    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int SW = (MAX_SLIPS < 1) ? 1 : $clog2(MAX_SLIPS + 1);
    localparam int WW = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);

    typedef enum logic [2:0] {IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL} state_t;

    logic [CHANNELS-1:0] lane_busy;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        state_t        state, state_nxt;
        logic [MW-1:0] match_cnt, match_nxt;
        logic [SW-1:0] slip_cnt, slip_nxt;
        logic [WW-1:0] wait_cnt, wait_nxt;
        logic          match;
        logic          slip_q, locked_q, error_q;

        assign match = rx_data[i*FACTOR +: FACTOR] == TRAIN_PATTERN;

        always_comb begin
            state_nxt = state;
            match_nxt = match_cnt;
            slip_nxt  = slip_cnt;
            wait_nxt  = wait_cnt;
            if (align_req) begin
                state_nxt = CHECK;
                match_nxt = '0;
                slip_nxt  = '0;
                wait_nxt  = '0;
            end else begin
                case (state)
                    CHECK: if (rx_valid) begin
                        if (match) begin
                            match_nxt = (int'(match_cnt) < MATCH_COUNT) ? match_cnt + 1'b1 : match_cnt;
                            if (int'(match_cnt) + 1 >= MATCH_COUNT)
                                state_nxt = LOCKED;
                        end else begin
                            match_nxt = '0;
                            state_nxt = (int'(slip_cnt) >= MAX_SLIPS) ? FAIL : SLIP;
                        end
                    end
                    SLIP: begin
                        slip_nxt  = (int'(slip_cnt) < MAX_SLIPS) ? slip_cnt + 1'b1 : slip_cnt;
                        wait_nxt  = '0;
                        state_nxt = WAIT;
                    end
                    // Give the SERDES time to settle after a slip; data is not looked at here.
                    WAIT: begin
                        if (int'(wait_cnt) + 1 >= SLIP_WAIT)
                            state_nxt = CHECK;
                        else
                            wait_nxt = wait_cnt + 1'b1;
                    end
                    IDLE, LOCKED, FAIL: state_nxt = state;
                    default: state_nxt = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                match_cnt <= '0;
                slip_cnt  <= '0;
                wait_cnt  <= '0;
                slip_q    <= 1'b0;
                locked_q  <= 1'b0;
                error_q   <= 1'b0;
            end else begin
                state     <= state_nxt;
                match_cnt <= match_nxt;
                slip_cnt  <= slip_nxt;
                wait_cnt  <= wait_nxt;
                slip_q    <= state_nxt == SLIP;
                locked_q  <= state_nxt == LOCKED;
                error_q   <= state_nxt == FAIL;
            end
        end

        assign bitslip[i]   = slip_q;
        assign ch_locked[i] = locked_q;
        assign ch_error[i]  = error_q;
        assign lane_busy[i] = state inside {CHECK, SLIP, WAIT};
    end

    assign busy = |lane_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_locked <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            all_locked <= &ch_locked;
            data_out   <= rx_data;
            data_valid <= rx_valid;
        end
    end
endmodule

// File: tb/tb_lvds_rx_word_aligner.sv
// tb_lvds_rx_word_aligner: directed training scenarios against a simple SERDES model;
// data path checked through an expected-word queue, flags checked at fixed points.
module tb_lvds_rx_word_aligner;
    localparam int CH = 4, F = 6, SW = 4;
    localparam logic [F-1:0] PAT = 6'b111000;

    logic clk = 1'b0, rst_n = 1'b0, align_req = 1'b0, rx_valid = 1'b0;
    logic [CH*F-1:0] rx_data = '0;
    logic [CH-1:0] bitslip, ch_locked, ch_error;
    logic all_locked, busy, data_valid;
    logic [CH*F-1:0] data_out;

    int n_assert = 0, n_fail = 0, cyc = 0;
    logic [CH*F-1:0] exp_q[$];
    int   rot[CH];
    logic zero[CH];
    logic force_ok[CH];
    int   slips[CH];
    int   last_slip[CH];

    always #5 clk = ~clk;

    lvds_rx_word_aligner dut (
        .clk(clk), .rst_n(rst_n), .align_req(align_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .bitslip(bitslip), .ch_locked(ch_locked),
        .ch_error(ch_error), .all_locked(all_locked), .busy(busy),
        .data_out(data_out), .data_valid(data_valid)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // SERDES model: each bitslip pulse removes one bit of rotation from the lane.
    function automatic logic [F-1:0] word(int i);
        logic [2*F-1:0] dbl = {PAT, PAT} >> (F - rot[i]);
        return zero[i] ? '0 : force_ok[i] ? PAT : dbl[F-1:0];
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (data_valid) begin
            if (exp_q.size() == 0) check("data_valid_unexpected", 32'(data_valid), 0);
            else check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        end
        for (int i = 0; i < CH; i++) begin
            if (bitslip[i]) begin
                if (slips[i] > 0) check("slip_gap", 32'(cyc - last_slip[i] >= SW + 1), 1);
                slips[i]++;
                last_slip[i] = cyc;
                rot[i] = (rot[i] + F - 1) % F;
            end
        end
    end

    task automatic step(input logic req, input logic v);
        align_req = req;
        rx_valid  = v;
        for (int i = 0; i < CH; i++) rx_data[i*F +: F] = v ? word(i) : '0;
        if (v) exp_q.push_back(rx_data);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run_valid(input int n);
        repeat (n) step(1'b0, 1'b1);
    endtask

    task automatic start();
        for (int i = 0; i < CH; i++) slips[i] = 0;
        step(1'b1, 1'b0);
    endtask

    task automatic cfg(input int r2, input logic z1);
        for (int i = 0; i < CH; i++) begin
            rot[i] = 0;
            zero[i] = 1'b0;
            force_ok[i] = 1'b0;
        end
        rot[2] = r2;
        zero[1] = z1;
    endtask

    task automatic wait_flags(input logic err, input logic [CH-1:0] mask, input int budget, input string name);
        int k = 0;
        while (((err ? ch_error : ch_locked) & mask) != mask && k < budget) begin
            step(1'b0, 1'b1);
            k++;
        end
        check(name, 32'((err ? ch_error : ch_locked) & mask), 32'(mask));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_bitslip"}, 32'(bitslip), 0);
        check({name, "_locked"}, 32'(ch_locked), 0);
        check({name, "_error"}, 32'(ch_error), 0);
        check({name, "_all_locked"}, 32'(all_locked), 0);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_data_valid"}, 32'(data_valid), 0);
        check({name, "_data_out"}, 32'(data_out), 0);
    endtask

    initial begin
        cfg(0, 1'b0);
        for (int i = 0; i < CH; i++) begin
            slips[i] = 0;
            last_slip[i] = 0;
        end
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        repeat (3) step(1'b0, 1'b1);
        check("idle_busy", 32'(busy), 0);
        check("idle_locked", 32'(ch_locked), 0);

        // 1: all lanes aligned from the start
        cfg(0, 1'b0);
        start();
        check("t1_busy", 32'(busy), 1);
        run_valid(15);
        check("t1_locked_15", 32'(ch_locked), 0);
        step(1'b0, 1'b1);
        check("t1_locked_16", 32'(ch_locked), 32'hF);
        check("t1_all_locked_lag", 32'(all_locked), 0);
        step(1'b0, 1'b1);
        check("t1_all_locked", 32'(all_locked), 1);
        check("t1_busy_done", 32'(busy), 0);
        check("t1_slips", 32'(slips[0] + slips[1] + slips[2] + slips[3]), 0);

        // 2: lane 2 rotated by two bits
        cfg(2, 1'b0);
        start();
        run_valid(16);
        check("t2_others_locked", 32'(ch_locked), 32'hB);
        check("t2_all_locked_early", 32'(all_locked), 0);
        wait_flags(1'b0, 4'hF, 40, "t2_lock");
        check("t2_lane2_slips", 32'(slips[2]), 2);
        check("t2_other_slips", 32'(slips[0] + slips[1] + slips[3]), 0);

        // 3: lane 1 stuck at zero exhausts its slips
        cfg(0, 1'b1);
        start();
        wait_flags(1'b1, 4'h2, 120, "t3_error");
        check("t3_error_vec", 32'(ch_error), 32'h2);
        check("t3_locked", 32'(ch_locked), 32'hD);
        check("t3_busy", 32'(busy), 0);
        check("t3_slips", 32'(slips[1]), 12);
        repeat (8) step(1'b0, 1'b1);
        check("t3_slips_held", 32'(slips[1]), 12);
        check("t3_error_held", 32'(ch_error), 32'h2);
        check("t3_all_locked", 32'(all_locked), 0);

        // 4: realign while lanes 0/3 locked and lane 1 waiting
        cfg(0, 1'b1);
        start();
        run_valid(16);
        check("t4_pre_locked", 32'(ch_locked), 32'hD);
        check("t4_pre_busy", 32'(busy), 1);
        check("t4_pre_bitslip", 32'(bitslip), 0);
        zero[1] = 1'b0;
        rot[1] = 0;
        step(1'b1, 1'b1);
        check("t4_clr_locked", 32'(ch_locked), 0);
        check("t4_clr_error", 32'(ch_error), 0);
        check("t4_clr_bitslip", 32'(bitslip), 0);
        check("t4_clr_busy", 32'(busy), 1);
        run_valid(16);
        check("t4_relock", 32'(ch_locked), 32'hF);
        step(1'b0, 1'b1);
        check("t4_all_locked", 32'(all_locked), 1);

        // 5a: half-rate rx_valid, lock counts valid words
        cfg(0, 1'b0);
        start();
        repeat (15) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        check("t5_locked_30cyc", 32'(ch_locked), 0);
        step(1'b0, 1'b1);
        check("t5_locked_16valid", 32'(ch_locked), 32'hF);
        // 5b: lane 0 misaligned word appears at match 15
        cfg(0, 1'b0);
        rot[0] = 1;
        force_ok[0] = 1'b1;
        start();
        run_valid(15);
        check("t5_locked_15", 32'(ch_locked), 0);
        force_ok[0] = 1'b0;
        step(1'b0, 1'b1);
        check("t5_slip_pulse", 32'(bitslip), 32'h1);
        check("t5_others_locked", 32'(ch_locked), 32'hE);
        wait_flags(1'b0, 4'hF, 40, "t5_lock");
        check("t5_slips", 32'(slips[0]), 1);

        // 6: reset while a bitslip pulse is high
        cfg(2, 1'b0);
        start();
        step(1'b0, 1'b1);
        check("t6_pulse", 32'(bitslip), 32'h4);
        align_req = 1'b0;
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("t6_hold");
        rst_n = 1'b1;
        rot[2] = 0;
        repeat (6) step(1'b0, 1'b1);
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_idle_locked", 32'(ch_locked), 0);
        check("t6_no_slips", 32'(slips[2]), 1);
        start();
        run_valid(16);
        check("t6_relock", 32'(ch_locked), 32'hF);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
